// File: rtl/rvh_l1d_axi_wb_sequencer.sv
// Dirty-line writeback sequencer for one L1D bank: latches a line, issues one
// INCR AW burst, streams the W beats and tracks B responses up to a bounded depth.
module rvh_l1d_axi_wb_sequencer #(
  parameter int unsigned PADDR_WIDTH     = 56,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned LINE_BEATS      = 8,
  parameter logic [3:0]  MASTER_ID       = 4'h0,
  parameter int unsigned TID_WIDTH       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_wb_req_valid,
  output logic                               o_wb_req_ready,
  input  logic [PADDR_WIDTH-1:0]             i_wb_req_paddr,
  input  logic [LINE_BEATS*DATA_WIDTH-1:0]   i_wb_req_data,
  output logic                               o_awvalid,
  input  logic                               i_awready,
  output logic [PADDR_WIDTH-1:0]             o_awaddr,
  output logic [4+TID_WIDTH-1:0]             o_awid,
  output logic [7:0]                         o_awlen,
  output logic [2:0]                         o_awsize,
  output logic [1:0]                         o_awburst,
  output logic                               o_wvalid,
  input  logic                               i_wready,
  output logic [DATA_WIDTH-1:0]              o_wdata,
  output logic [DATA_WIDTH/8-1:0]            o_wstrb,
  output logic                               o_wlast,
  input  logic                               i_bvalid,
  output logic                               o_bready,
  input  logic [4+TID_WIDTH-1:0]             i_bid,
  input  logic [1:0]                         i_bresp,
  output logic                               o_wb_done_valid,
  output logic [TID_WIDTH-1:0]               o_wb_done_id,
  output logic                               o_wb_done_err,
  output logic                               o_busy
);

  localparam int unsigned LINE_W = LINE_BEATS * DATA_WIDTH;
  localparam int unsigned BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [PADDR_WIDTH-1:0] r_addr;
  logic [LINE_W-1:0]      r_line;
  logic [BEAT_W-1:0]      r_beat;
  logic [TID_WIDTH-1:0]   r_tid;
  logic [OUT_W-1:0]       r_outstanding;
  logic                   r_done_valid;
  logic [TID_WIDTH-1:0]   r_done_id;
  logic                   r_done_err;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_last_hs;
  logic w_b_hs;
  logic w_unused;

  // Upper bid bits and the in-line offset of the request address carry no information here.
  assign w_unused = ^{i_bid[4+TID_WIDTH-1:TID_WIDTH], i_wb_req_paddr[5:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    w_last_hs      = 1'b0;
    o_wb_req_ready = 1'b0;
    o_awvalid      = 1'b0;
    o_wvalid       = 1'b0;
    o_wlast        = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_wb_req_ready = !rst && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
        if (i_wb_req_valid && o_wb_req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_AW;
        end
      end
      S_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) begin
          w_aw_hs     = 1'b1;
          w_state_nxt = S_W;
        end
      end
      S_W: begin
        o_wvalid = 1'b1;
        o_wlast  = (r_beat == BEAT_W'(LINE_BEATS - 1));
        if (i_wready) begin
          w_w_hs = 1'b1;
          if (o_wlast) begin
            w_last_hs   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_bready = (r_outstanding != '0);
  assign w_b_hs   = i_bvalid && o_bready;

  // Line is held in a shift register; the current beat always sits in the low word.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= {i_wb_req_paddr[PADDR_WIDTH-1:6], 6'd0};
      r_line <= i_wb_req_data;
    end else if (w_w_hs) begin
      r_line <= r_line >> DATA_WIDTH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat        <= '0;
      r_tid         <= '0;
      r_outstanding <= '0;
      r_done_valid  <= 1'b0;
      r_done_id     <= '0;
      r_done_err    <= 1'b0;
    end else begin
      if (w_aw_hs || w_last_hs) r_beat <= '0;
      else if (w_w_hs)          r_beat <= r_beat + BEAT_W'(1);
      if (w_last_hs) r_tid <= r_tid + TID_WIDTH'(1);
      case ({w_accept, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      r_done_valid <= w_b_hs;
      if (w_b_hs) begin
        r_done_id  <= i_bid[TID_WIDTH-1:0];
        r_done_err <= (i_bresp != 2'b00);
      end
    end
  end

  assign o_awaddr        = r_addr;
  assign o_awid          = {MASTER_ID, r_tid};
  assign o_awlen         = 8'(LINE_BEATS - 1);
  assign o_awsize        = 3'($clog2(DATA_WIDTH / 8));
  assign o_awburst       = 2'b01;
  assign o_wdata         = r_line[DATA_WIDTH-1:0];
  assign o_wstrb         = '1;
  assign o_wb_done_valid = r_done_valid;
  assign o_wb_done_id    = r_done_id;
  assign o_wb_done_err   = r_done_err;
  assign o_busy          = (r_state != S_IDLE) || (r_outstanding != '0);

endmodule

// File: tb/tb_rvh_l1d_axi_wb_sequencer.sv
// Directed bench for rvh_l1d_axi_wb_sequencer: vector table of single writebacks
// plus hand-written outstanding, same-cycle accept/B, reset and tid-wrap sequences.
module tb_rvh_l1d_axi_wb_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_wb_req_valid;
  logic         o_wb_req_ready;
  logic [55:0]  i_wb_req_paddr;
  logic [511:0] i_wb_req_data;
  logic         o_awvalid;
  logic         i_awready;
  logic [55:0]  o_awaddr;
  logic [7:0]   o_awid;
  logic [7:0]   o_awlen;
  logic [2:0]   o_awsize;
  logic [1:0]   o_awburst;
  logic         o_wvalid;
  logic         i_wready;
  logic [63:0]  o_wdata;
  logic [7:0]   o_wstrb;
  logic         o_wlast;
  logic         i_bvalid;
  logic         o_bready;
  logic [7:0]   i_bid;
  logic [1:0]   i_bresp;
  logic         o_wb_done_valid;
  logic [3:0]   o_wb_done_id;
  logic         o_wb_done_err;
  logic         o_busy;

  int n_cmp = 0;
  int n_err = 0;

  rvh_l1d_axi_wb_sequencer dut (
    .clk(clk), .rst(rst),
    .i_wb_req_valid(i_wb_req_valid), .o_wb_req_ready(o_wb_req_ready),
    .i_wb_req_paddr(i_wb_req_paddr), .i_wb_req_data(i_wb_req_data),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_awid(o_awid), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
    .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bid(i_bid), .i_bresp(i_bresp),
    .o_wb_done_valid(o_wb_done_valid), .o_wb_done_id(o_wb_done_id),
    .o_wb_done_err(o_wb_done_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [55:0] paddr;
    logic [63:0] mult;
    logic [63:0] offs;
    int          stall;
    bit          toggle;
    logic [1:0]  bresp;
    logic [55:0] exp_addr;
    logic [7:0]  exp_awid;
    bit          exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_line(input logic [63:0] mult, input logic [63:0] offs);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = mult * 64'(k) + offs;
    return l;
  endfunction

  // Presents a request, waits (bounded) for ready, then scrambles the inputs after accept.
  task automatic accept_req(input logic [55:0] paddr, input logic [511:0] line);
    int n;
    n = 0;
    i_wb_req_valid = 1'b1;
    i_wb_req_paddr = paddr;
    i_wb_req_data  = line;
    while (!o_wb_req_ready && n < 64) begin tick(); n++; end
    chk("req_ready_wait", 64'(n < 64), 64'd1);
    tick();
    i_wb_req_valid = 1'b0;
    i_wb_req_paddr = ~paddr;
    i_wb_req_data  = ~line;
  endtask

  task automatic run_burst(input logic [55:0] exp_addr, input logic [7:0] exp_awid,
                           input logic [63:0] mult, input logic [63:0] offs,
                           input int stall, input bit toggle);
    int k, cyc;
    for (int s = 0; s < stall; s++) begin
      chk("aw_hold_valid", 64'(o_awvalid), 64'd1);
      chk("aw_hold_addr", 64'(o_awaddr), 64'(exp_addr));
      tick();
    end
    i_awready = 1'b1;
    chk("awvalid", 64'(o_awvalid), 64'd1);
    chk("awaddr", 64'(o_awaddr), 64'(exp_addr));
    chk("awid", 64'(o_awid), 64'(exp_awid));
    chk("awlen", 64'(o_awlen), 64'd7);
    chk("awsize", 64'(o_awsize), 64'd3);
    chk("awburst", 64'(o_awburst), 64'd1);
    chk("wvalid_in_aw", 64'(o_wvalid), 64'd0);
    tick();
    i_awready = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 64) begin
      i_wready = toggle ? (cyc % 2 == 0) : 1'b1;
      chk("wvalid", 64'(o_wvalid), 64'd1);
      chk("wdata", o_wdata, mult * 64'(k) + offs);
      chk("wlast", 64'(o_wlast), 64'(k == 7));
      chk("awvalid_in_w", 64'(o_awvalid), 64'd0);
      if (k == 0) chk("wstrb", 64'(o_wstrb), 64'hFF);
      if (i_wready) k++;
      tick();
      cyc++;
    end
    i_wready = 1'b0;
    chk("w_beats", 64'(k), 64'd8);
    chk("w_done_no_extra", 64'(o_wvalid), 64'd0);
  endtask

  task automatic b_resp(input logic [7:0] bid, input logic [1:0] bresp,
                        input logic [3:0] exp_id, input bit exp_err);
    i_bvalid = 1'b1;
    i_bid    = bid;
    i_bresp  = bresp;
    chk("bready", 64'(o_bready), 64'd1);
    tick();
    i_bvalid = 1'b0;
    chk("done_valid", 64'(o_wb_done_valid), 64'd1);
    chk("done_id", 64'(o_wb_done_id), 64'(exp_id));
    chk("done_err", 64'(o_wb_done_err), 64'(exp_err));
    tick();
    chk("done_pulse_end", 64'(o_wb_done_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{56'h0000_8000_1234_5678, 64'h1111, 64'h0, 0, 1'b0, 2'b00,
                56'h0000_8000_1234_5640, 8'h00, 1'b0};
    vecs[1] = '{56'hFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'hA5, 5, 1'b1, 2'b01,
                56'hFF_FFFF_FFFF_FFC0, 8'h01, 1'b1};
    vecs[2] = '{56'h00_0000_0000_003F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7, 1, 1'b0, 2'b11,
                56'h00_0000_0000_0000, 8'h02, 1'b1};
    vecs[3] = '{56'h12_3456_789A_BCC0, 64'h8000_0000_0000_0001, 64'h0, 0, 1'b1, 2'b00,
                56'h12_3456_789A_BCC0, 8'h03, 1'b0};

    rst = 1'b1;
    i_wb_req_valid = 1'b0; i_wb_req_paddr = '0; i_wb_req_data = '0;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bid = '0; i_bresp = '0;
    tick(); tick();
    chk("rst_awvalid", 64'(o_awvalid), 64'd0);
    chk("rst_wvalid", 64'(o_wvalid), 64'd0);
    chk("rst_bready", 64'(o_bready), 64'd0);
    chk("rst_done", 64'(o_wb_done_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_ready", 64'(o_wb_req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(o_wb_req_ready), 64'd1);

    // Table of single writebacks, each followed by its B response.
    for (int i = 0; i < 4; i++) begin
      accept_req(vecs[i].paddr, make_line(vecs[i].mult, vecs[i].offs));
      chk("busy_after_accept", 64'(o_busy), 64'd1);
      run_burst(vecs[i].exp_addr, vecs[i].exp_awid, vecs[i].mult, vecs[i].offs,
                vecs[i].stall, vecs[i].toggle);
      b_resp(vecs[i].exp_awid, vecs[i].bresp, vecs[i].exp_awid[3:0], vecs[i].exp_err);
      chk("idle_not_busy", 64'(o_busy), 64'd0);
    end

    // Outstanding limit: two bursts without B, third blocked until one B returns.
    accept_req(56'h100, make_line(64'h11, 64'h1));
    run_burst(56'h100, 8'h04, 64'h11, 64'h1, 0, 1'b0);
    accept_req(56'h140, make_line(64'h22, 64'h2));
    run_burst(56'h140, 8'h05, 64'h22, 64'h2, 0, 1'b0);
    i_wb_req_valid = 1'b1;
    i_wb_req_paddr = 56'h180;
    i_wb_req_data  = make_line(64'h33, 64'h3);
    for (int c = 0; c < 3; c++) begin
      chk("full_ready_low", 64'(o_wb_req_ready), 64'd0);
      chk("full_no_aw", 64'(o_awvalid), 64'd0);
      tick();
    end
    i_bvalid = 1'b1; i_bid = 8'h01; i_bresp = 2'b10;
    tick();
    i_bvalid = 1'b0;
    chk("ooo_done_valid", 64'(o_wb_done_valid), 64'd1);
    chk("ooo_done_id", 64'(o_wb_done_id), 64'd1);
    chk("ooo_done_err", 64'(o_wb_done_err), 64'd1);
    chk("freed_ready", 64'(o_wb_req_ready), 64'd1);
    accept_req(56'h180, make_line(64'h33, 64'h3));
    run_burst(56'h180, 8'h06, 64'h33, 64'h3, 0, 1'b0);
    b_resp(8'h04, 2'b00, 4'h4, 1'b0);
    b_resp(8'h06, 2'b00, 4'h6, 1'b0);
    chk("drained_busy", 64'(o_busy), 64'd0);

    // Same-cycle accept and B with one outstanding: count stays at one.
    accept_req(56'h200, make_line(64'h44, 64'h4));
    run_burst(56'h200, 8'h07, 64'h44, 64'h4, 0, 1'b0);
    i_wb_req_valid = 1'b1;
    i_wb_req_paddr = 56'h240;
    i_wb_req_data  = make_line(64'h55, 64'h5);
    i_bvalid = 1'b1; i_bid = 8'h07; i_bresp = 2'b00;
    chk("sim_ready", 64'(o_wb_req_ready), 64'd1);
    chk("sim_bready", 64'(o_bready), 64'd1);
    tick();
    i_wb_req_valid = 1'b0;
    i_bvalid = 1'b0;
    chk("sim_done_valid", 64'(o_wb_done_valid), 64'd1);
    chk("sim_done_id", 64'(o_wb_done_id), 64'd7);
    chk("sim_busy", 64'(o_busy), 64'd1);
    run_burst(56'h240, 8'h08, 64'h55, 64'h5, 0, 1'b0);
    chk("sim_busy_idle", 64'(o_busy), 64'd1);
    chk("sim_bready_one", 64'(o_bready), 64'd1);
    b_resp(8'h08, 2'b00, 4'h8, 1'b0);
    chk("sim_bready_zero", 64'(o_bready), 64'd0);
    chk("sim_not_busy", 64'(o_busy), 64'd0);

    // Reset during W beat 3 abandons the burst.
    accept_req(56'h300, make_line(64'h66, 64'h6));
    i_awready = 1'b1;
    tick();
    i_awready = 1'b0;
    i_wready = 1'b1;
    tick(); tick(); tick();
    i_wready = 1'b0;
    chk("pre_rst_beat3", o_wdata, 64'h66 * 64'd3 + 64'h6);
    rst = 1'b1;
    tick();
    chk("mid_rst_awvalid", 64'(o_awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(o_wvalid), 64'd0);
    chk("mid_rst_bready", 64'(o_bready), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_done", 64'(o_wb_done_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(o_wb_req_ready), 64'd1);

    // Tid wrap across 17 writebacks starting from tid 0 after the reset.
    for (int i = 0; i < 17; i++) begin
      accept_req(56'h1000 + 56'(i * 64), make_line(64'h0F0F + 64'(i), 64'(i)));
      run_burst(56'h1000 + 56'(i * 64), {4'h0, 4'(i % 16)}, 64'h0F0F + 64'(i), 64'(i), 0, 1'b0);
      b_resp({4'h0, 4'(i % 16)}, 2'b00, 4'(i % 16), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
